// File: rtl/bus_pkg.sv
// Shared types and default constants for the memory-mapped bus fabric.
package bus_pkg;

  // Fabric FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } fabric_state_t;

  // Default bus geometry and the read value returned with an error response.
  localparam int                BUS_AW       = 8;
  localparam int                BUS_DW       = 8;
  localparam logic [BUS_DW-1:0] BUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/mmio_addr_decoder.sv
// Region decoder: the top SEL_BITS address bits pick a slave; regions at or
// above NS are unmapped.
module mmio_addr_decoder #(
  parameter int AW       = 8,
  parameter int NS       = 4,
  parameter int SEL_BITS = 2
) (
  input  logic [AW-1:0]       addr,
  output logic [SEL_BITS-1:0] index,
  output logic                valid
);

  // Slice the region bits and flag addresses that fall outside the mapped slaves.
  always_comb begin
    index = addr[AW-1 -: SEL_BITS];
    valid = (int'(index) < NS);
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Memory-mapped interconnect between one CPU master and NS slaves: region
// decode, ready/wait-state handshake with timeout, registered read return
// and a bus-error response for unmapped addresses or unresponsive slaves.
module mmio_bus_fabric
  import bus_pkg::*;
#(
  parameter int          AW       = BUS_AW,
  parameter int          DW       = BUS_DW,
  parameter int          NS       = 4,
  parameter int          SEL_BITS = 2,
  parameter int          TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = {DW{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [AW-1:0]    m_addr,
  input  logic [DW-1:0]    m_wdata,
  output logic             m_ready,
  output logic [DW-1:0]    m_rdata,
  output logic             m_err,
  output logic [NS-1:0]    s_sel,
  output logic             s_we,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ready
);

  // Counter must be able to hold TIMEOUT itself without wrapping.
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  fabric_state_t state_r, state_n;
  logic [NS-1:0]   sel_r, sel_n;
  logic            we_r, we_n;
  logic [AW-1:0]   addr_r, addr_n;
  logic [DW-1:0]   wdata_r, wdata_n;
  logic [DW-1:0]   rdata_r, rdata_n;
  logic            ready_r, ready_n;
  logic            err_r, err_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic            dec_err_r, dec_err_n;

  logic [SEL_BITS-1:0] dec_index_s;
  logic                dec_valid_s;
  logic [NS-1:0]       dec_onehot_s;
  logic [DW-1:0]       rd_mux_s;
  logic                ready_hit_s;

  mmio_addr_decoder #(
    .AW       (AW),
    .NS       (NS),
    .SEL_BITS (SEL_BITS)
  ) u_dec (
    .addr  (m_addr),
    .index (dec_index_s),
    .valid (dec_valid_s)
  );

  // One-hot slave select for the incoming address; empty on unmapped regions.
  always_comb begin
    dec_onehot_s = {NS{1'b0}};
    for (int i = 0; i < NS; i++) begin
      if (dec_valid_s && (int'(dec_index_s) == i)) begin
        dec_onehot_s[i] = 1'b1;
      end else begin
        dec_onehot_s[i] = 1'b0;
      end
    end
  end

  // Read mux and completion detect follow the latched select, so unselected
  // slaves' ready bits and data never matter.
  always_comb begin
    rd_mux_s    = {DW{1'b0}};
    ready_hit_s = |(s_ready & sel_r);
    for (int i = 0; i < NS; i++) begin
      if (sel_r[i]) begin
        rd_mux_s = rd_mux_s | s_rdata[i*DW +: DW];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Next-state and next-output logic; every output is a flop fed from here.
  // An unmapped address spends one cycle in ACCESS with no slave selected so
  // its error response lines up with a zero-wait slave completion.
  always_comb begin
    state_n   = state_r;
    sel_n     = sel_r;
    we_n      = we_r;
    addr_n    = addr_r;
    wdata_n   = wdata_r;
    rdata_n   = rdata_r;
    ready_n   = 1'b0;
    err_n     = 1'b0;
    cnt_n     = cnt_r;
    dec_err_n = dec_err_r;
    case (state_r)
      IDLE: begin
        if (m_req) begin
          we_n      = m_we;
          addr_n    = m_addr;
          wdata_n   = m_wdata;
          cnt_n     = {CW{1'b0}};
          dec_err_n = ~dec_valid_s;
          sel_n     = dec_onehot_s;
          state_n   = ACCESS;
        end else begin
          sel_n = {NS{1'b0}};
        end
      end
      ACCESS: begin
        if (dec_err_r) begin
          sel_n   = {NS{1'b0}};
          ready_n = 1'b1;
          err_n   = 1'b1;
          rdata_n = ERR_DATA;
          state_n = ERR;
        end else if (ready_hit_s) begin
          sel_n   = {NS{1'b0}};
          ready_n = 1'b1;
          rdata_n = we_r ? {DW{1'b0}} : rd_mux_s;
          state_n = DONE;
        end else if (cnt_r == TO_V) begin
          sel_n   = {NS{1'b0}};
          ready_n = 1'b1;
          err_n   = 1'b1;
          rdata_n = ERR_DATA;
          state_n = ERR;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        sel_n   = {NS{1'b0}};
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the slave select immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      sel_r     <= {NS{1'b0}};
      we_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      rdata_r   <= {DW{1'b0}};
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      dec_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      sel_r     <= sel_n;
      we_r      <= we_n;
      addr_r    <= addr_n;
      wdata_r   <= wdata_n;
      rdata_r   <= rdata_n;
      ready_r   <= ready_n;
      err_r     <= err_n;
      cnt_r     <= cnt_n;
      dec_err_r <= dec_err_n;
    end
  end

  assign m_ready = ready_r;
  assign m_rdata = rdata_r;
  assign m_err   = err_r;
  assign s_sel   = sel_r;
  assign s_we    = we_r;
  assign s_addr  = addr_r;
  assign s_wdata = wdata_r;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: a four-slave instance for the main
// traffic and a three-slave instance for the unmapped-region case.
module tb_mmio_bus_fabric;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_req = 1'b0;
  logic        m_we = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_wdata = 8'h00;
  logic [31:0] s_rdata = 32'h0;
  logic [3:0]  s_ready = 4'b0000;
  logic        m_ready, m_err, s_we;
  logic [7:0]  m_rdata, s_addr, s_wdata;
  logic [3:0]  s_sel;

  logic [23:0] s_rdata3 = 24'h0;
  logic [2:0]  s_ready3 = 3'b111;
  logic        m_ready3, m_err3, s_we3;
  logic [7:0]  m_rdata3, s_addr3, s_wdata3;
  logic [2:0]  s_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bus_fabric #(.AW(8), .DW(8), .NS(4), .SEL_BITS(2), .TIMEOUT(15), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err), .s_sel(s_sel), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  mmio_bus_fabric #(.AW(8), .DW(8), .NS(3), .SEL_BITS(2), .TIMEOUT(15), .ERR_DATA(8'hFF)) dut3 (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready3), .m_rdata(m_rdata3), .m_err(m_err3), .s_sel(s_sel3), .s_we(s_we3),
    .s_addr(s_addr3), .s_wdata(s_wdata3), .s_rdata(s_rdata3), .s_ready(s_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready0", m_ready, 0);
    chk("rst_err", m_err, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_sel", s_sel, 0);
    chk("rst_we", s_we, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    step();
    reset = 1'b1;
    step();

    // 1. Zero-wait read from slave 1
    s_rdata[15:8] = 8'hA5;
    s_ready = 4'b0010;
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h45;
    step();                                   // k+1
    m_req = 1'b0;
    chk("t1_sel", s_sel, 4'b0010);
    chk("t1_addr", s_addr, 8'h45);
    chk("t1_ready_early", m_ready, 0);
    step();                                   // k+2
    chk("t1_ready", m_ready, 1);
    chk("t1_rdata", m_rdata, 8'hA5);
    chk("t1_err", m_err, 0);
    chk("t1_sel_drop", s_sel, 0);
    step();                                   // k+3
    chk("t1_pulse_end", m_ready, 0);

    // 2. Write with three wait states; other slaves' ready bits high meanwhile
    s_ready = 4'b1011;
    m_req = 1'b1; m_we = 1'b1; m_addr = 8'h80; m_wdata = 8'h3C;
    step();                                   // k+1
    m_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("t2_sel_wait", s_sel, 4'b0100);
      chk("t2_we", s_we, 1);
      chk("t2_wdata", s_wdata, 8'h3C);
      chk("t2_ready_wait", m_ready, 0);
      step();                                 // k+2 .. k+4
    end
    s_ready = 4'b0100;
    chk("t2_sel_last", s_sel, 4'b0100);
    chk("t2_ready_k4", m_ready, 0);
    step();                                   // k+5
    s_ready = 4'b0000;
    chk("t2_ready", m_ready, 1);
    chk("t2_err", m_err, 0);
    chk("t2_rdata_wr", m_rdata, 8'h00);
    chk("t2_sel_drop", s_sel, 0);
    step();
    chk("t2_pulse_end", m_ready, 0);

    // 3. Unmapped region on the three-slave fabric (slave 3 exists on dut)
    s_rdata[31:24] = 8'h99;
    s_ready = 4'b1000;
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'hC0;
    step();                                   // k+1
    m_req = 1'b0;
    chk("t3_sel3", s_sel3, 3'b000);
    chk("t3_ready3_early", m_ready3, 0);
    chk("t3_sel4", s_sel, 4'b1000);
    step();                                   // k+2
    chk("t3_ready3", m_ready3, 1);
    chk("t3_err3", m_err3, 1);
    chk("t3_rdata3", m_rdata3, 8'hFF);
    chk("t3_sel3_k2", s_sel3, 3'b000);
    chk("t3_ready4", m_ready, 1);
    chk("t3_err4", m_err, 0);
    chk("t3_rdata4", m_rdata, 8'h99);
    step();
    chk("t3_pulse_end", m_ready3, 0);
    s_ready = 4'b0000;

    // 4. Timeout on slave 0
    s_rdata[7:0] = 8'h5A;
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h00;
    step();                                   // k+1
    m_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("t4_sel_hold", s_sel, 4'b0001);
      chk("t4_no_ready", m_ready, 0);
      step();                                 // k+2 .. k+17
    end
    chk("t4_ready", m_ready, 1);
    chk("t4_err", m_err, 1);
    chk("t4_rdata", m_rdata, 8'hFF);
    chk("t4_sel_drop", s_sel, 0);
    step();
    chk("t4_pulse_end", m_ready, 0);

    // 4b. Ready on the final edge beats the timeout
    m_req = 1'b1; m_addr = 8'h01;
    step();                                   // k+1
    m_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      chk("t4b_no_ready", m_ready, 0);
      step();                                 // k+2 .. k+16
    end
    s_ready = 4'b0001;
    chk("t4b_sel_last", s_sel, 4'b0001);
    step();                                   // k+17
    s_ready = 4'b0000;
    chk("t4b_ready", m_ready, 1);
    chk("t4b_err", m_err, 0);
    chk("t4b_rdata", m_rdata, 8'h5A);
    step();

    // 5. Reset in the middle of an access
    m_req = 1'b1; m_addr = 8'h40;
    step();                                   // k+1
    m_req = 1'b0;
    step();                                   // k+2, still waiting
    chk("t5_sel_before", s_sel, 4'b0010);
    #2 reset = 1'b0;
    #1;
    chk("t5_sel_async", s_sel, 0);
    chk("t5_ready_async", m_ready, 0);
    step();
    chk("t5_no_ready_a", m_ready, 0);
    step();
    chk("t5_no_ready_b", m_ready, 0);
    #2 reset = 1'b1;
    s_rdata[15:8] = 8'h77;
    s_ready = 4'b0010;
    m_req = 1'b1; m_addr = 8'h45;
    step();                                   // k+1
    m_req = 1'b0;
    chk("t5_sel_after", s_sel, 4'b0010);
    step();                                   // k+2
    chk("t5_ready_after", m_ready, 1);
    chk("t5_rdata_after", m_rdata, 8'h77);
    chk("t5_err_after", m_err, 0);
    step();

    // 6. Back-to-back reads to slaves 0 and 3 with m_req held high
    s_rdata[7:0] = 8'h11;
    s_rdata[31:24] = 8'hEE;
    s_ready = 4'b1001;
    m_req = 1'b1; m_addr = 8'h05;
    step();                                   // k+1
    chk("t6_sel_a", s_sel, 4'b0001);
    m_addr = 8'hC5;
    step();                                   // k+2
    chk("t6_ready_a", m_ready, 1);
    chk("t6_rdata_a", m_rdata, 8'h11);
    step();                                   // k+3
    chk("t6_gap_ready", m_ready, 0);
    chk("t6_gap_sel", s_sel, 0);
    step();                                   // k+4
    m_req = 1'b0;
    chk("t6_sel_b", s_sel, 4'b1000);
    chk("t6_addr_b", s_addr, 8'hC5);
    step();                                   // k+5
    chk("t6_ready_b", m_ready, 1);
    chk("t6_rdata_b", m_rdata, 8'hEE);
    chk("t6_err_b", m_err, 0);
    step();
    chk("t6_pulse_end", m_ready, 0);
    chk("t6_idle_sel", s_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
